// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned REG_W    = 4;
    localparam int unsigned MC_CNT_W = 4;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [REG_W-1:0] PC_REG = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_e;

    // M-stage result is younger than W, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] ra,
        input logic [REG_W-1:0] wa_m,
        input logic             rw_m,
        input logic [REG_W-1:0] wa_w,
        input logic             rw_w
    );
        if (rw_m && (wa_m == ra))      return FWD_MEM;
        else if (rw_w && (wa_w == ra)) return FWD_WB;
        else                           return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-side view of the hazard controller: register addresses, stage flags and controls.
interface hazard_unit_if #(parameter int unsigned CNT_W = 16);

    logic [3:0]       RA1D, RA2D, RA1E, RA2E;
    logic [3:0]       WA3E, WA3M, WA3W;
    logic             RegWriteE, RegWriteM, RegWriteW;
    logic             MemtoRegE, IgRnE;
    logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW;
    logic             BranchTakenE, MultiStartE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE;
    logic             FlushD, FlushE, FlushM;
    logic             MultiBusy;
    logic [CNT_W-1:0] StallCnt;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, IgRnE,
               PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MultiStartE,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, MultiBusy, StallCnt
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, IgRnE,
               PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MultiStartE,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, MultiBusy, StallCnt
    );

endinterface

// File: rtl/hazard_unit_mc_seq.sv
// Multi-cycle execute sequencer: holds E for MC_LAT cycles per op.
module mc_seq
    import hazard_pkg::*;
#(
    parameter int unsigned MC_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic busy_o
);

    localparam logic        MULTI_EN = (MC_LAT > 1);
    localparam int unsigned LOAD     = (MC_LAT > 1) ? (MC_LAT - 2) : 0;

    mc_state_e             state_q, state_d;
    logic [MC_CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Start cycle counts as the first hold cycle; cnt==0 in BUSY is the release cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i && MULTI_EN) begin
                    busy_o  = 1'b1;
                    state_d = BUSY;
                    cnt_d   = MC_CNT_W'(LOAD);
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    busy_o = 1'b1;
                    cnt_d  = cnt_q - MC_CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: operand forwarding, stalls/flushes, multi-cycle hold and stall counter.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_unit_if.slave hz
);

    logic             multi_busy;
    logic             ldr_stall, pc_wr_pend;
    logic             stall_f;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    mc_seq #(.MC_LAT(MC_LAT)) u_mc_seq (
        .clk     (clk),
        .rst_n   (reset),
        .start_i (hz.MultiStartE),
        .busy_o  (multi_busy)
    );

    // Reads of PC or of an ignored Rn never take a forwarded value.
    assign hz.ForwardAE = (hz.IgRnE || (hz.RA1E == PC_REG)) ? FWD_RF :
                          fwd_sel(hz.RA1E, hz.WA3M, hz.RegWriteM, hz.WA3W, hz.RegWriteW);
    assign hz.ForwardBE = (hz.RA2E == PC_REG) ? FWD_RF :
                          fwd_sel(hz.RA2E, hz.WA3M, hz.RegWriteM, hz.WA3W, hz.RegWriteW);

    assign ldr_stall  = hz.MemtoRegE && hz.RegWriteE &&
                        ((hz.RA1D == hz.WA3E) || (hz.RA2D == hz.WA3E));
    assign pc_wr_pend = hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;
    assign stall_f    = ldr_stall || pc_wr_pend || multi_busy;

    // While E holds a multi-cycle op, E must not be cleared; M receives bubbles instead.
    assign hz.StallF    = stall_f;
    assign hz.StallD    = ldr_stall || multi_busy;
    assign hz.StallE    = multi_busy;
    assign hz.FlushD    = pc_wr_pend || hz.PCSrcW || hz.BranchTakenE;
    assign hz.FlushE    = (ldr_stall || hz.BranchTakenE) && !multi_busy;
    assign hz.FlushM    = multi_busy;
    assign hz.MultiBusy = multi_busy;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_f && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign hz.StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: MC_LAT=4/CNT_W=4 main instance plus an MC_LAT=1 instance.
module tb_hazard_unit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    hazard_unit_if #(.CNT_W(4))  if0 ();
    hazard_unit_if #(.CNT_W(16)) if1 ();

    hazard_unit #(.MC_LAT(4), .CNT_W(4))  dut  (.clk(clk), .reset(reset), .hz(if0.slave));
    hazard_unit #(.MC_LAT(1), .CNT_W(16)) dut1 (.clk(clk), .reset(reset), .hz(if1.slave));

    // Second instance sees identical pipeline inputs.
    assign if1.RA1D = if0.RA1D;           assign if1.RA2D = if0.RA2D;
    assign if1.RA1E = if0.RA1E;           assign if1.RA2E = if0.RA2E;
    assign if1.WA3E = if0.WA3E;           assign if1.WA3M = if0.WA3M;
    assign if1.WA3W = if0.WA3W;           assign if1.RegWriteE = if0.RegWriteE;
    assign if1.RegWriteM = if0.RegWriteM; assign if1.RegWriteW = if0.RegWriteW;
    assign if1.MemtoRegE = if0.MemtoRegE; assign if1.IgRnE = if0.IgRnE;
    assign if1.PCSrcD = if0.PCSrcD;       assign if1.PCSrcE = if0.PCSrcE;
    assign if1.PCSrcM = if0.PCSrcM;       assign if1.PCSrcW = if0.PCSrcW;
    assign if1.BranchTakenE = if0.BranchTakenE;
    assign if1.MultiStartE  = if0.MultiStartE;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic clr_inputs();
        if0.RA1D = '0; if0.RA2D = '0; if0.RA1E = '0; if0.RA2E = '0;
        if0.WA3E = '0; if0.WA3M = '0; if0.WA3W = '0;
        if0.RegWriteE = 1'b0; if0.RegWriteM = 1'b0; if0.RegWriteW = 1'b0;
        if0.MemtoRegE = 1'b0; if0.IgRnE = 1'b0;
        if0.PCSrcD = 1'b0; if0.PCSrcE = 1'b0; if0.PCSrcM = 1'b0; if0.PCSrcW = 1'b0;
        if0.BranchTakenE = 1'b0; if0.MultiStartE = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clr_inputs();
        #1;
        checks++; if (if0.MultiBusy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", if0.MultiBusy); end
        checks++; if (if0.StallCnt !== 4'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", if0.StallCnt); end
        checks++; if (if0.ForwardAE !== 2'b00) begin errors++; $display("FAIL rst_fwdA got=%b exp=00", if0.ForwardAE); end
        checks++; if (if0.StallF !== 1'b0) begin errors++; $display("FAIL rst_stallF got=%b exp=0", if0.StallF); end
        checks++; if (if0.FlushD !== 1'b0) begin errors++; $display("FAIL rst_flushD got=%b exp=0", if0.FlushD); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        clr_inputs();
        if0.RA1E = 4'd3; if0.WA3M = 4'd3; if0.RegWriteM = 1'b1; if0.WA3W = 4'd3; if0.RegWriteW = 1'b1;
        #1;
        checks++; if (if0.ForwardAE !== 2'b10) begin errors++; $display("FAIL fwdA_mem got=%b exp=10", if0.ForwardAE); end
        if0.RegWriteM = 1'b0; #1;
        checks++; if (if0.ForwardAE !== 2'b01) begin errors++; $display("FAIL fwdA_wb got=%b exp=01", if0.ForwardAE); end
        if0.RA1E = 4'hF; if0.WA3W = 4'hF; #1;
        checks++; if (if0.ForwardAE !== 2'b00) begin errors++; $display("FAIL fwdA_pc got=%b exp=00", if0.ForwardAE); end
        if0.RA1E = 4'd3; if0.WA3W = 4'd3; if0.IgRnE = 1'b1; #1;
        checks++; if (if0.ForwardAE !== 2'b00) begin errors++; $display("FAIL fwdA_igrn got=%b exp=00", if0.ForwardAE); end
        // B operand ignores IgRnE
        if0.RA2E = 4'd3; if0.RegWriteM = 1'b1; #1;
        checks++; if (if0.ForwardBE !== 2'b10) begin errors++; $display("FAIL fwdB_mem got=%b exp=10", if0.ForwardBE); end
        if0.RegWriteM = 1'b0; #1;
        checks++; if (if0.ForwardBE !== 2'b01) begin errors++; $display("FAIL fwdB_wb got=%b exp=01", if0.ForwardBE); end
        if0.RA2E = 4'hF; if0.WA3W = 4'hF; #1;
        checks++; if (if0.ForwardBE !== 2'b00) begin errors++; $display("FAIL fwdB_pc got=%b exp=00", if0.ForwardBE); end
        if0.RA2E = 4'd4; if0.WA3M = 4'd7; if0.RegWriteM = 1'b1; if0.WA3W = 4'd8; #1;
        checks++; if (if0.ForwardBE !== 2'b00) begin errors++; $display("FAIL fwdB_none got=%b exp=00", if0.ForwardBE); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        clr_inputs();
        if0.MemtoRegE = 1'b1; if0.RegWriteE = 1'b1; if0.WA3E = 4'd5; if0.RA2D = 4'd5; if0.RA1D = 4'd1;
        #1;
        checks++; if ({if0.StallF, if0.StallD, if0.FlushE} !== 3'b111) begin errors++; $display("FAIL ldr_stall got=%b exp=111", {if0.StallF, if0.StallD, if0.FlushE}); end
        checks++; if ({if0.StallE, if0.FlushM} !== 2'b00) begin errors++; $display("FAIL ldr_noE got=%b exp=00", {if0.StallE, if0.FlushM}); end
        @(negedge clk);
        clr_inputs();
        #1;
        checks++; if ({if0.StallF, if0.StallD, if0.FlushE} !== 3'b000) begin errors++; $display("FAIL ldr_clear got=%b exp=000", {if0.StallF, if0.StallD, if0.FlushE}); end
        checks++; if (if0.StallCnt !== 4'd1) begin errors++; $display("FAIL ldr_cnt got=%0d exp=1", if0.StallCnt); end
        // Load whose write is disabled creates no hazard even on RA1D match
        if0.MemtoRegE = 1'b1; if0.WA3E = 4'd9; if0.RA1D = 4'd9; #1;
        checks++; if (if0.StallF !== 1'b0) begin errors++; $display("FAIL ldr_norw got=%b exp=0", if0.StallF); end
    endtask

    task automatic test_branch();
        @(negedge clk);
        clr_inputs();
        if0.BranchTakenE = 1'b1;
        #1;
        checks++; if ({if0.FlushD, if0.FlushE, if0.StallF} !== 3'b110) begin errors++; $display("FAIL br_flush got=%b exp=110", {if0.FlushD, if0.FlushE, if0.StallF}); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            clr_inputs();
            if0.PCSrcD = (k == 0); if0.PCSrcE = (k == 1); if0.PCSrcM = (k == 2); if0.PCSrcW = (k == 3);
            #1;
            checks++; if (if0.StallF !== (k < 3)) begin errors++; $display("FAIL pc_stallF[%0d] got=%b exp=%b", k, if0.StallF, (k < 3)); end
            checks++; if (if0.FlushD !== 1'b1) begin errors++; $display("FAIL pc_flushD[%0d] got=%b exp=1", k, if0.FlushD); end
        end
        @(negedge clk);
        clr_inputs();
        #1;
        checks++; if ({if0.FlushD, if0.StallF} !== 2'b00) begin errors++; $display("FAIL pc_clear got=%b exp=00", {if0.FlushD, if0.StallF}); end
        checks++; if (if0.StallCnt !== 4'd4) begin errors++; $display("FAIL pc_cnt got=%0d exp=4", if0.StallCnt); end
    endtask

    task automatic test_back_to_back();
        logic exp_busy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            clr_inputs();
            if0.MultiStartE = 1'b1;
            if (c == 1) begin if0.MemtoRegE = 1'b1; if0.RegWriteE = 1'b1; if0.WA3E = 4'd6; if0.RA1D = 4'd6; end
            if (c == 2) if0.BranchTakenE = 1'b1;
            #1;
            checks++; if ({if0.MultiBusy, if0.StallE, if0.FlushM, if0.StallF} !== {4{exp_busy[c]}}) begin
                errors++; $display("FAIL mc_hold[%0d] got=%b exp=%b", c, {if0.MultiBusy, if0.StallE, if0.FlushM, if0.StallF}, {4{exp_busy[c]}}); end
            checks++; if (if1.MultiBusy !== 1'b0) begin errors++; $display("FAIL mc_lat1[%0d] got=%b exp=0", c, if1.MultiBusy); end
            if (c == 1) begin
                checks++; if ({if0.StallD, if0.FlushE} !== 2'b10) begin errors++; $display("FAIL mc_ldr got=%b exp=10", {if0.StallD, if0.FlushE}); end
            end
            if (c == 2) begin
                checks++; if ({if0.FlushD, if0.FlushE} !== 2'b10) begin errors++; $display("FAIL mc_br got=%b exp=10", {if0.FlushD, if0.FlushE}); end
            end
        end
        @(negedge clk);
        clr_inputs();
        #1;
        checks++; if (if0.MultiBusy !== 1'b0) begin errors++; $display("FAIL mc_idle got=%b exp=0", if0.MultiBusy); end
        checks++; if (if0.StallCnt !== 4'd10) begin errors++; $display("FAIL mc_cnt got=%0d exp=10", if0.StallCnt); end
    endtask

    task automatic test_reset_mid_busy();
        logic exp_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        @(negedge clk);
        clr_inputs();
        if0.MultiStartE = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        checks++; if (if0.MultiBusy !== 1'b1) begin errors++; $display("FAIL rmb_pre got=%b exp=1", if0.MultiBusy); end
        reset = 1'b0;
        if0.MultiStartE = 1'b0;
        #1;
        checks++; if (if0.MultiBusy !== 1'b0) begin errors++; $display("FAIL rmb_busy got=%b exp=0", if0.MultiBusy); end
        checks++; if (if0.StallCnt !== 4'd0) begin errors++; $display("FAIL rmb_cnt got=%0d exp=0", if0.StallCnt); end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            clr_inputs();
            if0.MultiStartE = (c < 4);
            #1;
            checks++; if (if0.MultiBusy !== exp_busy[c]) begin errors++; $display("FAIL rmb_fresh[%0d] got=%b exp=%b", c, if0.MultiBusy, exp_busy[c]); end
        end
        checks++; if (if0.StallCnt !== 4'd3) begin errors++; $display("FAIL rmb_cnt_after got=%0d exp=3", if0.StallCnt); end
    endtask

    task automatic test_stallcnt_sat();
        int exp_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            clr_inputs();
            if0.PCSrcD = 1'b1;
            #1;
            exp_cnt = (3 + i > 15) ? 15 : 3 + i;
            checks++; if (if0.StallCnt !== 4'(exp_cnt)) begin errors++; $display("FAIL sat[%0d] got=%0d exp=%0d", i, if0.StallCnt, exp_cnt); end
        end
        @(negedge clk);
        clr_inputs();
        @(negedge clk);
        #1;
        checks++; if (if0.StallCnt !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", if0.StallCnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_back_to_back();
        test_reset_mid_busy();
        test_stallcnt_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
